if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch front end directly upstream of the instruction ROM. Owns the program counter, drives the ROM chip-enable and address, captures the returned (already byte-swapped) instruction into a 2-entry fetch queue, and hands {pc, inst} to the decode-side pipeline register over a valid/ready handshake. Handles branch redirects and exception flushes with a fixed priority and without ever presenting a wrong-path instruction.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset (`RstEnable`)
- flush_i  in  1  exception/pipeline flush; highest-priority redirect
- new_pc_i  in  `InstAddrBus`  target PC when flush_i=1
- branch_flag_i  in  1  branch taken, resolved in execute
- branch_target_address_i  in  `InstAddrBus`  target PC when branch_flag_i=1
- rom_ce_o  out  1  ROM chip enable (`ChipEnable`/`ChipDisable`)
- rom_addr_o  out  `InstAddrBus`  ROM byte address (= current PC)
- rom_inst_i  in  `InstBus`  ROM data, combinational, valid same cycle as address
- id_ready_i  in  1  downstream accepts entry this cycle
- id_valid_o  out  1  head of fetch queue is valid
- id_pc_o  out  `InstAddrBus`  PC of head entry
- id_inst_o  out  `InstBus`  instruction of head entry
- misalign_o  out  1  one-cycle pulse: redirect target had addr[1:0]≠0

## Operation
- State: pc register, ce register, 2-entry queue (count 0..2), misalign pulse register.
- ce: `ChipDisable` while rst; `ChipEnable` from first cycle after rst deasserts. rom_ce_o=ce; rom_addr_o=pc.
- Push: ce=1 AND no redirect this cycle AND (count<2 OR pop this cycle). Push writes {pc, rom_inst_i}; pc <= pc+4 (modulo 2^32, 0xFFFF_FFFC wraps to 0).
- No push: pc holds (fetch retried next cycle; ROM is stateless).
- Pop: id_valid_o AND id_ready_i; head advances. Simultaneous push+pop at count=2 allowed, count stays 2.
- Redirect priority: flush_i > branch_flag_i > sequential.
  - Redirect cycle: queue cleared (count<=0), no push, pc <= target with addr[1:0] forced to 00.
  - Any pop in the redirect cycle is still honoured (the head presented that cycle is consumed by downstream); entry is then discarded with the queue.
  - target[1:0]≠0 -> misalign_o=1 next cycle only.
- Instruction data passed through unmodified; byte order is the ROM's responsibility.
- id_pc_o/id_inst_o = `ZeroWord` when id_valid_o=0.

## Timing
- Reset (rst=1 at edge): pc=RESET_PC, ce=0, count=0, misalign_o=0; therefore rom_ce_o=0, rom_addr_o=RESET_PC, id_valid_o=0, id_pc_o=id_inst_o=`ZeroWord`.
- Fetch latency: address issued cycle N -> entry visible at id_* cycle N+1.
- Redirect asserted cycle N -> rom_addr_o=target cycle N+1 -> id_valid_o with target cycle N+2; id_valid_o=0 in N+1.
- Sustained throughput 1 instr/cycle with id_ready_i=1.
- Backpressure: after 2 unpopped pushes, fetch stalls; pc frozen at next unfetched address.
- rst mid-operation overrides flush/branch/handshake: queue lost, state as above.
- flush_i and branch_flag_i together: new_pc_i wins, branch ignored.

## Structure
- Shared defines.v supplies `InstAddrBus`, `InstBus`, `ZeroWord`, `ChipEnable`, `ChipDisable`, `RstEnable`; no new globals except RESET_PC default `InstResetPC` added there.
- One sub-module: fetch_queue (2-entry synchronous FIFO, 64-bit entries, push/pop/clear, count, synchronous reset). PC/redirect logic stays in if_fetch.

## Test plan
- Reset then free-run, id_ready_i=1: id_pc_o = 0x0,0x4,0x8,… one per cycle starting 2nd cycle after rst drop; rom_ce_o=0 during reset.
- id_ready_i=0 for 5 cycles from pc=0x8: exactly 2 entries (0x8,0xC) held, rom_addr_o stays 0x10; release -> 0x8,0xC,0x10 in order, no duplicates/gaps.
- branch_flag_i=1 target 0x40 while queue holds 0x10,0x14: next cycle id_valid_o=0, following cycle id_pc_o=0x40; 0x10/0x14 never popped after the branch cycle.
- flush_i (new_pc_i=0x100) and branch_flag_i (0x40) same cycle: fetch resumes at 0x100.
- Branch target 0x42: fetch at 0x40, misalign_o high exactly one cycle.
- pc=0xFFFF_FFFC sequential: next id_pc_o=0x0000_0000; rst asserted mid-stream with full queue -> id_valid_o=0 next cycle, restart at RESET_PC.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared widths, constants and the fetch-queue entry type for the instruction-fetch front end.
package if_fetch_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned COUNT_W     = 2;

  localparam logic [INST_ADDR_W-1:0] ZERO_WORD     = '0;
  localparam logic [INST_ADDR_W-1:0] INST_RESET_PC = 32'h0000_0000;
  localparam logic                   CHIP_ENABLE   = 1'b1;
  localparam logic                   CHIP_DISABLE  = 1'b0;
  localparam logic                   RST_ENABLE    = 1'b1;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
    return {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// Two-entry synchronous FIFO of {pc, inst}; clear drops all entries, pop on empty and push on full are ignored.
module fetch_queue
  import if_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               clear,
  input  fetch_entry_t       din,
  output fetch_entry_t       head_c,
  output logic [COUNT_W-1:0] count
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  always_comb begin
    do_pop  = pop && (count != COUNT_W'(0));
    do_push = push && ((count < COUNT_W'(2)) || do_pop);
    head_c  = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear && !rst) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + COUNT_W'(1);
        2'b01:   count <= count - COUNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: PC, ROM enable/address, redirect handling and a 2-entry queue toward decode.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = INST_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic [INST_ADDR_W-1:0] new_pc_i,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_address_i,
  output logic                   rom_ce_o,
  output logic [INST_ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0]      rom_inst_i,
  input  logic                   id_ready_i,
  output logic                   id_valid_o,
  output logic [INST_ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0]      id_inst_o,
  output logic                   misalign_o
);

  logic                   redirect;
  logic [INST_ADDR_W-1:0] target;
  logic                   pop;
  logic                   push;
  logic [COUNT_W-1:0]     count;
  fetch_entry_t           head;
  fetch_entry_t           fetched;

  // Flush outranks branch; a redirect cycle never pushes, so no wrong-path entry reaches decode.
  always_comb begin
    redirect     = flush_i || branch_flag_i;
    target       = flush_i ? new_pc_i : branch_target_address_i;
    id_valid_o   = (count != COUNT_W'(0));
    pop          = id_valid_o && id_ready_i;
    push         = (rom_ce_o == CHIP_ENABLE) && !redirect &&
                   ((count < COUNT_W'(2)) || pop);
    fetched.pc   = rom_addr_o;
    fetched.inst = rom_inst_i;
    id_pc_o      = id_valid_o ? head.pc   : ZERO_WORD;
    id_inst_o    = id_valid_o ? head.inst : INST_W'(0);
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      rom_addr_o <= RESET_PC;
      rom_ce_o   <= CHIP_DISABLE;
      misalign_o <= 1'b0;
    end else begin
      rom_ce_o   <= CHIP_ENABLE;
      misalign_o <= redirect && (target[1:0] != 2'b00);
      if (redirect) begin
        rom_addr_o <= word_align(target);
      end else if (push) begin
        rom_addr_o <= rom_addr_o + INST_ADDR_W'(4);
      end
    end
  end

  fetch_queue u_queue (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .clear  (redirect),
    .din    (fetched),
    .head_c (head),
    .count  (count)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed vector table plus randomized traffic against a queue-based model.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic        branch = 1'b0;
  logic [31:0] btgt = '0;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        misalign;

  always #5 clk = ~clk;

  // ROM stand-in: a distinct, address-derived word for every location.
  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
  endfunction

  assign rom_inst = rom_f(rom_addr);

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .flush_i                 (flush),
    .new_pc_i                (new_pc),
    .branch_flag_i           (branch),
    .branch_target_address_i (btgt),
    .rom_ce_o                (rom_ce),
    .rom_addr_o              (rom_addr),
    .rom_inst_i              (rom_inst),
    .id_ready_i              (ready),
    .id_valid_o              (id_valid),
    .id_pc_o                 (id_pc),
    .id_inst_o               (id_inst),
    .misalign_o              (misalign)
  );

  typedef struct {
    logic        rst;
    logic        fl;
    logic [31:0] npc;
    logic        br;
    logic [31:0] bt;
    logic        rdy;
    logic        ce;
    logic [31:0] addr;
    logic        val;
    logic [31:0] pc;
    logic        mis;
  } vec_t;

  vec_t tbl[25];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Reference model: PC, enable, misalign flag and a queue of fetched PCs.
  logic [31:0] m_pc;
  logic        m_ce;
  logic        m_mis;
  logic [31:0] mq[$];

  function automatic vec_t mk(input logic r, input logic f, input logic [31:0] n,
                              input logic b, input logic [31:0] t, input logic y,
                              input logic ce, input logic [31:0] ad, input logic v,
                              input logic [31:0] p, input logic m);
    vec_t x;
    x.rst = r; x.fl = f; x.npc = n; x.br = b; x.bt = t; x.rdy = y;
    x.ce = ce; x.addr = ad; x.val = v; x.pc = p; x.mis = m;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    logic [31:0] t;
    if (rst) begin
      m_pc = 32'h0; m_ce = 1'b0; m_mis = 1'b0; mq.delete();
    end else begin
      t = flush ? new_pc : btgt;
      m_mis = (flush || branch) && (t[1:0] != 2'b00);
      if (mq.size() > 0 && ready) void'(mq.pop_front());
      if (flush || branch) begin
        mq.delete();
        m_pc = t & 32'hFFFF_FFFC;
      end else if (m_ce && mq.size() < 2) begin
        mq.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
      m_ce = 1'b1;
    end
  endtask

  task automatic check_model();
    logic        v;
    logic [31:0] p;
    v = (mq.size() > 0);
    p = v ? mq[0] : 32'h0;
    chk("m_rom_ce", 32'(rom_ce), 32'(m_ce));
    chk("m_rom_addr", rom_addr, m_pc);
    chk("m_id_valid", 32'(id_valid), 32'(v));
    chk("m_id_pc", id_pc, p);
    chk("m_id_inst", id_inst, v ? rom_f(p) : 32'h0);
    chk("m_misalign", 32'(misalign), 32'(m_mis));
  endtask

  task automatic cycle_end();
    @(posedge clk);
    model_step();
    cyc++;
  endtask

  initial begin
    // Directed sequence: bring-up, backpressure, branch, flush+branch, misaligned target, wrap, mid-stream reset.
    tbl[0]  = mk(1,0,0,0,0,1,            0,32'h0,0,32'h0,0);
    tbl[1]  = mk(0,0,0,0,0,1,            0,32'h0,0,32'h0,0);
    tbl[2]  = mk(0,0,0,0,0,1,            1,32'h0,0,32'h0,0);
    tbl[3]  = mk(0,0,0,0,0,1,            1,32'h4,1,32'h0,0);
    tbl[4]  = mk(0,0,0,0,0,1,            1,32'h8,1,32'h4,0);
    tbl[5]  = mk(0,0,0,0,0,0,            1,32'hC,1,32'h8,0);
    tbl[6]  = mk(0,0,0,0,0,0,            1,32'h10,1,32'h8,0);
    tbl[7]  = mk(0,0,0,0,0,0,            1,32'h10,1,32'h8,0);
    tbl[8]  = mk(0,0,0,0,0,0,            1,32'h10,1,32'h8,0);
    tbl[9]  = mk(0,0,0,0,0,0,            1,32'h10,1,32'h8,0);
    tbl[10] = mk(0,0,0,0,0,1,            1,32'h10,1,32'h8,0);
    tbl[11] = mk(0,0,0,0,0,1,            1,32'h14,1,32'hC,0);
    tbl[12] = mk(0,0,0,1,32'h40,1,       1,32'h18,1,32'h10,0);
    tbl[13] = mk(0,0,0,0,0,1,            1,32'h40,0,32'h0,0);
    tbl[14] = mk(0,1,32'h100,1,32'h40,1, 1,32'h44,1,32'h40,0);
    tbl[15] = mk(0,0,0,0,0,1,            1,32'h100,0,32'h0,0);
    tbl[16] = mk(0,0,0,1,32'h42,1,       1,32'h104,1,32'h100,0);
    tbl[17] = mk(0,0,0,0,0,1,            1,32'h40,0,32'h0,1);
    tbl[18] = mk(0,1,32'hFFFF_FFFC,0,0,1,1,32'h44,1,32'h40,0);
    tbl[19] = mk(0,0,0,0,0,1,            1,32'hFFFF_FFFC,0,32'h0,0);
    tbl[20] = mk(0,0,0,0,0,0,            1,32'h0,1,32'hFFFF_FFFC,0);
    tbl[21] = mk(1,0,0,0,0,0,            1,32'h4,1,32'hFFFF_FFFC,0);
    tbl[22] = mk(0,0,0,0,0,1,            0,32'h0,0,32'h0,0);
    tbl[23] = mk(0,0,0,0,0,1,            1,32'h0,0,32'h0,0);
    tbl[24] = mk(0,0,0,0,0,1,            1,32'h4,1,32'h0,0);

    // Initial reset: outputs are undefined before the first edge, so not checked here.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b1; flush = 1'b0; branch = 1'b0; ready = 1'b0;
      cycle_end();
    end

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; flush = tbl[i].fl; new_pc = tbl[i].npc;
      branch = tbl[i].br; btgt = tbl[i].bt; ready = tbl[i].rdy;
      chk("t_rom_ce", 32'(rom_ce), 32'(tbl[i].ce));
      chk("t_rom_addr", rom_addr, tbl[i].addr);
      chk("t_id_valid", 32'(id_valid), 32'(tbl[i].val));
      chk("t_id_pc", id_pc, tbl[i].pc);
      chk("t_id_inst", id_inst, tbl[i].val ? rom_f(tbl[i].pc) : 32'h0);
      chk("t_misalign", 32'(misalign), 32'(tbl[i].mis));
      check_model();
      cycle_end();
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst    = ($urandom_range(199) == 0);
      flush  = ($urandom_range(9) == 0);
      branch = ($urandom_range(5) == 0);
      ready  = ($urandom_range(3) != 0);
      case ($urandom_range(3))
        0:       begin new_pc = $urandom(); btgt = $urandom(); end
        1:       begin new_pc = 32'hFFFF_FFF0 + 32'($urandom_range(15));
                       btgt   = 32'hFFFF_FFE0 + 32'($urandom_range(31)); end
        default: begin new_pc = 32'($urandom_range(255)); btgt = 32'($urandom_range(1023)); end
      endcase
      check_model();
      cycle_end();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
